// File: rtl/rvv_stim_sequencer.sv
// RVV stimulus sequencer: replays a stimulus table into a vector core, tracks outstanding
// instructions, sources load data and sinks stores. Define STIM_RAND_STALL_EN for LFSR load/store stalls.

package rvv_stim_pkg;
  typedef logic [4:0]  insn_id_t;
  typedef logic [31:0] vrf_data_t;

  typedef struct packed {
    logic [7:0] vl;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vec_context_t;

  typedef struct packed {
    logic [31:0]  insn;
    insn_id_t     id;
    vec_context_t ctx;
  } stimulus_t;
endpackage

module rvv_stim_load_ch import rvv_stim_pkg::*; #(
  parameter int unsigned Step = 2,
  parameter int unsigned Init = 0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      stall_i,
  input  logic      ready_i,
  output logic      valid_o,
  output vrf_data_t data_o
);
  vrf_data_t cnt_q;

  assign valid_o = !stall_i;
  assign data_o  = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                cnt_q <= vrf_data_t'(Init);
    else if (valid_o && ready_i) cnt_q <= cnt_q + vrf_data_t'(Step);
  end
endmodule

module rvv_stim_sequencer import rvv_stim_pkg::*; #(
  parameter int unsigned NumStimulus      = 16,
  parameter int unsigned NumLoadCh        = 2,
  parameter int unsigned OutstandingDepth = 4,
  parameter int unsigned CommitLatency    = 2,
  localparam int unsigned AW = (NumStimulus > 1) ? $clog2(NumStimulus) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            tbl_we_i,
  input  logic [AW-1:0]                   tbl_addr_i,
  input  stimulus_t                       tbl_data_i,
  input  logic                            start_i,
  input  logic                            flush_req_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [31:0]                     insn_o,
  output insn_id_t                        insn_id_o,
  output vec_context_t                    vec_context_o,
  output logic                            flush_o,
  output logic                            insn_can_commit_o,
  output insn_id_t                        insn_can_commit_id_o,
  input  logic                            done_i,
  input  insn_id_t                        done_insn_id_i,
  input  logic                            illegal_insn_i,
  output logic [NumLoadCh-1:0]            load_op_valid_o,
  input  logic [NumLoadCh-1:0]            load_op_ready_i,
  output vrf_data_t [NumLoadCh-1:0]       load_op_o,
  input  logic                            store_op_valid_i,
  input  vrf_data_t                       store_op_i,
  output logic                            store_op_gnt_o,
  output logic [31:0]                     store_cnt_o,
  output vrf_data_t                       store_xor_o,
  output logic                            sim_done_o,
  output logic                            flushed_o,
  output logic                            err_o
);
  localparam int unsigned CW   = $clog2(NumStimulus + 1);
  localparam int unsigned PW   = (OutstandingDepth > 1) ? $clog2(OutstandingDepth) : 1;
  localparam int unsigned OW   = $clog2(OutstandingDepth + 1);
  localparam int unsigned AgeW = $clog2(CommitLatency + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   issue_cnt_q, done_cnt_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]   fifo_cnt_q;
  stimulus_t       tbl_q [NumStimulus];
  insn_id_t        id_q  [OutstandingDepth];
  logic [AgeW-1:0] age_q [OutstandingDepth];
  stimulus_t       cur;
  logic            hs, pop, fifo_empty, stall;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OutstandingDepth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Table is deliberately not reset so a stimulus set survives a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (tbl_we_i && (state_q == IDLE || state_q == DONE)) tbl_q[tbl_addr_i] <= tbl_data_i;
  end

  assign cur           = tbl_q[issue_cnt_q[AW-1:0]];
  assign insn_o        = cur.insn;
  assign insn_id_o     = cur.id;
  assign vec_context_o = cur.ctx;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign valid_o    = (state_q == RUN) && (fifo_cnt_q != OW'(OutstandingDepth));
  assign hs         = valid_o && ready_i;
  assign pop        = done_i && !fifo_empty;

  assign insn_can_commit_o    = !fifo_empty && (age_q[rd_ptr_q] >= AgeW'(CommitLatency));
  assign insn_can_commit_id_o = id_q[rd_ptr_q];
  assign sim_done_o           = (state_q == DONE);

  // Ages saturate at the commit latency; a push lands with age 0.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < OutstandingDepth; i++) begin
      if (age_q[i] != AgeW'(CommitLatency)) age_q[i] <= age_q[i] + AgeW'(1);
    end
    if (hs) begin
      id_q[wr_ptr_q]  <= cur.id;
      age_q[wr_ptr_q] <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      flush_o     <= 1'b0;
      flushed_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      flush_o <= 1'b0;
      if (hs)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
        done_cnt_q <= done_cnt_q + CW'(1);
      end
      case ({hs, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + OW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - OW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q     <= RUN;
            issue_cnt_q <= '0;
            done_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            err_o       <= 1'b0;
            flushed_o   <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            issue_cnt_q <= issue_cnt_q + CW'(1);
            if (issue_cnt_q == CW'(NumStimulus - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_cnt_q == CW'(NumStimulus) && fifo_empty) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase

      if (flush_req_i && (state_q == RUN || state_q == DRAIN)) begin
        flush_o    <= 1'b1;
        flushed_o  <= 1'b1;
        state_q    <= DONE;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end

      // Error sets come last so they win over the clear done by start_i.
      if (done_i && (fifo_empty || done_insn_id_i != id_q[rd_ptr_q])) err_o <= 1'b1;
      if (illegal_insn_i) err_o <= 1'b1;
    end
  end

`ifdef STIM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  for (genvar c = 0; c < NumLoadCh; c++) begin : g_ld
    rvv_stim_load_ch #(.Step(NumLoadCh), .Init(c)) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .stall_i (stall),
      .ready_i (load_op_ready_i[c]),
      .valid_o (load_op_valid_o[c]),
      .data_o  (load_op_o[c])
    );
  end

  assign store_op_gnt_o = store_op_valid_i && !stall;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      store_cnt_o <= '0;
      store_xor_o <= '0;
    end else if (store_op_gnt_o) begin
      store_cnt_o <= store_cnt_o + 32'd1;
      store_xor_o <= store_xor_o ^ store_op_i;
    end
  end
endmodule
